led_bank_sequencer: RTL and testbench

- Drives the four 8-bit LED banks (bank0..bank3) with one of four selectable animation patterns.
- Pattern steps advance on a prescaled tick derived from clk.
- A valid/ready request port switches modes. Switches take effect only on a tick boundary, so patterns never change mid-step.
- Top-level peripheral: sits between board control logic (buttons or a host register) and the LED pins.

---
 rtl/led_bank_sequencer_pkg.sv | 21 ++
 rtl/led_bank_sequencer_if.sv | 21 ++
 rtl/led_bank_sequencer_prescaler.sv | 26 ++
 rtl/led_bank_sequencer.sv | 129 ++++++++++++
 tb/tb_led_bank_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/led_bank_sequencer_pkg.sv
// Shared types and constants for the LED bank sequencer.
// Mode encoding matches the 2-bit request field.
package led_seq_pkg;

    localparam int BANK_W    = 8;
    localparam int NUM_BANKS = 4;
    localparam int NUM_LEDS  = 32;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_OFF   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } state_e;

endpackage

// File: rtl/led_bank_sequencer_if.sv
// Mode-change request channel (valid/ready).
// Master is the board control side, slave is the sequencer.
interface led_bank_sequencer_if;

    logic       mode_req_valid;
    logic [1:0] mode_req_mode;
    logic       mode_req_ready;

    modport master (
        output mode_req_valid,
        output mode_req_mode,
        input  mode_req_ready
    );

    modport slave (
        input  mode_req_valid,
        input  mode_req_mode,
        output mode_req_ready
    );

endinterface

// File: rtl/led_bank_sequencer_prescaler.sv
// Free-running prescaler with a registered wrap tick.
// tick is high exactly while the counter holds all-ones.
module led_prescaler #(
    parameter int PRESCALE_W = 20
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] PRE_LAST =
        {{(PRESCALE_W-1){1'b1}}, 1'b0};

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt + PRESCALE_W'(1);
            tick <= (cnt == PRE_LAST);
        end
    end

endmodule

// File: rtl/led_bank_sequencer.sv
// Four-bank LED animation sequencer with tick-aligned mode switching.
// Banks are decoded from registered state only.
module led_bank_sequencer
    import led_seq_pkg::*;
#(
    parameter int PRESCALE_W = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_bank_sequencer_if.slave  req,
    input  logic                 pause,
    output logic                 tick_out,
    output logic [1:0]           cur_mode,
    output logic [BANK_W-1:0]    bank0,
    output logic [BANK_W-1:0]    bank1,
    output logic [BANK_W-1:0]    bank2,
    output logic [BANK_W-1:0]    bank3
);

    logic                tick;
    state_e              state;
    state_e              state_nxt;
    mode_e               mode_q;
    mode_e               pending;
    logic [BANK_W-1:0]   count;
    logic [4:0]          scan_pos;
    logic                scan_down;
    logic                blink_phase;
    logic                ready;
    logic                accept;
    logic                apply;
    logic                step;
    logic [NUM_LEDS-1:0] leds;

    led_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        apply     = 1'b0;
        unique case (state)
            ST_RUN: begin
                ready = 1'b1;
                if (req.mode_req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (tick) begin
                    apply     = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // The switch tick reloads the pattern instead of stepping it.
    assign step = tick && !pause && (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_COUNT;
            pending     <= MODE_COUNT;
            count       <= '0;
            scan_pos    <= '0;
            scan_down   <= 1'b0;
            blink_phase <= 1'b0;
        end else begin
            if (accept) pending <= mode_e'(req.mode_req_mode);
            if (apply) begin
                mode_q      <= pending;
                count       <= '0;
                scan_pos    <= '0;
                scan_down   <= 1'b0;
                blink_phase <= 1'b1;
            end else if (step) begin
                unique case (mode_q)
                    MODE_COUNT: count <= count + 8'd1;
                    MODE_SCAN: begin
                        if (!scan_down) begin
                            scan_pos <= scan_pos + 5'd1;
                            if (scan_pos == 5'd30) scan_down <= 1'b1;
                        end else begin
                            scan_pos <= scan_pos - 5'd1;
                            if (scan_pos == 5'd1) scan_down <= 1'b0;
                        end
                    end
                    MODE_BLINK: blink_phase <= ~blink_phase;
                    MODE_OFF:   ;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        leds = '0;
        unique case (mode_q)
            MODE_COUNT: leds = {NUM_BANKS{count}};
            MODE_SCAN:  leds = NUM_LEDS'(1) << scan_pos;
            MODE_BLINK: leds = {NUM_LEDS{blink_phase}};
            MODE_OFF:   leds = '0;
            default:    leds = '0;
        endcase
    end

    assign req.mode_req_ready = ready;
    assign tick_out           = tick;
    assign cur_mode           = mode_q;
    assign bank0              = leds[7:0];
    assign bank1              = leds[15:8];
    assign bank2              = leds[23:16];
    assign bank3              = leds[31:24];

endmodule

// File: tb/tb_led_bank_sequencer.sv
// Directed scoreboard bench for led_bank_sequencer, PRESCALE_W=4.
// Stimulus and sampling happen on the falling clock edge.
module tb_led_bank_sequencer;

    localparam int PW = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       pause = 1'b0;
    logic       tick_out;
    logic [1:0] cur_mode;
    logic [7:0] bank0;
    logic [7:0] bank1;
    logic [7:0] bank2;
    logic [7:0] bank3;

    led_bank_sequencer_if req_if ();

    led_bank_sequencer #(
        .PRESCALE_W(PW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_if.slave),
        .pause   (pause),
        .tick_out(tick_out),
        .cur_mode(cur_mode),
        .bank0   (bank0),
        .bank1   (bank1),
        .bank2   (bank2),
        .bank3   (bank3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string       tag;
        logic [31:0] leds;
        logic [1:0]  mode;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] leds_now();
        return {bank3, bank2, bank1, bank0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] l,
                        input logic [1:0] m);
        exp_t e;
        e.tag  = tag;
        e.leds = l;
        e.mode = m;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_leds"}, leds_now(), e.leds);
        chk({e.tag, "_mode"}, 32'(cur_mode), 32'(e.mode));
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick_out !== 1'b1 && n < 40);
        if (tick_out !== 1'b1) begin
            checks++;
            fails++;
            $error("FAIL tick_timeout: observed no tick expected tick");
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            wait_tick();
            @(negedge clk);
        end
    endtask

    task automatic send_req(input logic [1:0] m);
        req_if.mode_req_valid = 1'b1;
        req_if.mode_req_mode  = m;
        @(negedge clk);
        req_if.mode_req_valid = 1'b0;
    endtask

    initial begin
        int n;
        int pulses;
        bit scan_seen;

        req_if.mode_req_valid = 1'b0;
        req_if.mode_req_mode  = 2'd0;

        // Reset and first ticks
        repeat (3) @(negedge clk);
        chk("rst_banks", leds_now(), 32'h0);
        chk("rst_ready", 32'(req_if.mode_req_ready), 32'd1);
        chk("rst_mode", 32'(cur_mode), 32'd0);
        chk("rst_tick", 32'(tick_out), 32'd0);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick_out !== 1'b1 && n < 40);
        chk("first_tick_cycle", n, 32'd15);
        @(negedge clk);
        push("count1", 32'h01010101, 2'd0);
        pop_check();
        ticks(2);
        push("count3", 32'h03030303, 2'd0);
        pop_check();
        ticks(253);
        push("count_wrap", 32'h0, 2'd0);
        pop_check();

        // SCAN sweep
        send_req(2'd1);
        chk("scan_req_ready", 32'(req_if.mode_req_ready), 32'd0);
        ticks(1);
        push("scan0", 32'h0000_0001, 2'd1);
        pop_check();
        ticks(8);
        push("scan8", 32'h0000_0100, 2'd1);
        pop_check();
        ticks(23);
        push("scan31", 32'h8000_0000, 2'd1);
        pop_check();
        ticks(1);
        push("scan_bounce", 32'h4000_0000, 2'd1);
        pop_check();
        ticks(30);
        push("scan_back0", 32'h0000_0001, 2'd1);
        pop_check();
        ticks(1);
        push("scan_up1", 32'h0000_0002, 2'd1);
        pop_check();

        // Handshake timing into BLINK
        repeat (6) @(negedge clk);
        send_req(2'd2);
        chk("hs_ready_low", 32'(req_if.mode_req_ready), 32'd0);
        wait_tick();
        chk("hs_ready_tick", 32'(req_if.mode_req_ready), 32'd0);
        @(negedge clk);
        push("blink_on", 32'hFFFF_FFFF, 2'd2);
        pop_check();
        chk("hs_ready_back", 32'(req_if.mode_req_ready), 32'd1);
        ticks(1);
        push("blink_off", 32'h0, 2'd2);
        pop_check();

        // Request landing on a RUN tick
        send_req(2'd0);
        ticks(1);
        push("count_restart", 32'h0, 2'd0);
        pop_check();
        ticks(5);
        push("count5", 32'h05050505, 2'd0);
        pop_check();
        wait_tick();
        send_req(2'd3);
        push("simul_step", 32'h06060606, 2'd0);
        pop_check();
        chk("simul_ready", 32'(req_if.mode_req_ready), 32'd0);
        ticks(1);
        push("simul_off", 32'h0, 2'd3);
        pop_check();

        // Pause
        send_req(2'd0);
        ticks(17);
        push("pause_start", 32'h10101010, 2'd0);
        pop_check();
        pause = 1'b1;
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (tick_out === 1'b1) pulses++;
        end
        chk("pause_pulses", pulses, 32'd5);
        push("pause_hold", 32'h10101010, 2'd0);
        pop_check();
        send_req(2'd2);
        ticks(1);
        push("pause_switch", 32'hFFFF_FFFF, 2'd2);
        pop_check();
        pause = 1'b0;

        // Reset during SWITCH drops the pending SCAN
        send_req(2'd1);
        chk("mid_rst_pre_ready", 32'(req_if.mode_req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_banks", leds_now(), 32'h0);
        chk("mid_rst_mode", 32'(cur_mode), 32'd0);
        chk("mid_rst_ready", 32'(req_if.mode_req_ready), 32'd1);
        #1 rst_n = 1'b1;
        scan_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (cur_mode === 2'd1) scan_seen = 1'b1;
        end
        chk("no_scan_after_rst", 32'(scan_seen), 32'd0);
        push("post_rst_count", 32'h03030303, 2'd0);
        pop_check();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
